// File: rtl/ucsbece154b_mem_pkg.sv
// Shared types and constants for the wait-state data memory.
// Also holds the alignment rule used when DMEM_MISALIGN_EN is defined.
package ucsbece154b_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  localparam int LAT_CNT_W = 4;

  function automatic logic misaligned(input logic [3:0] be, input logic [1:0] a);
    logic m;
    if (be == BE_WORD) begin
      m = (a != 2'b00);
    end else if ((be == BE_HALF_LO) || (be == BE_HALF_HI)) begin
      m = a[0];
    end else begin
      m = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/ucsbece154b_bram_be.sv
// Synchronous word array with per-byte write enables.
// The read port returns the contents from before a same-edge write.
module ucsbece154b_bram_be #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic              clr,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wd,
  output logic [31:0]       rd
);

  logic [31:0] mem_r [2**ADDR_W];
  logic [31:0] rd_r;

  // byte-lane write; the array itself is never reset
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) begin
          mem_r[idx][8*n +: 8] <= wd[8*n +: 8];
        end
      end
    end
  end

  // read register holds its value between accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r <= 32'd0;
    end else if (en) begin
      rd_r <= clr ? 32'd0 : mem_r[idx];
    end
  end

  assign rd = rd_r;

endmodule

// File: rtl/ucsbece154b_dmem_wait.sv
// Data memory with LATENCY wait states and a req/ready/rvalid handshake.
// Optional alignment fault reporting is enabled with `define DMEM_MISALIGN_EN.
module ucsbece154b_dmem_wait
  import ucsbece154b_mem_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wd_i,
  input  logic [3:0]  be_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rd_o,
  output logic        err_o
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

  state_e               state_r, next_state_s;
  logic [LAT_CNT_W-1:0] cnt_r;
  logic                 we_r, mis_r, ready_r, rvalid_r, err_r;
  logic [ADDR_W-1:0]    idx_r;
  logic [31:0]          wd_r;
  logic [3:0]           be_r;
  logic                 accept_s, access_s, mis_s;
  logic                 unused_addr_s;

  assign unused_addr_s = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

`ifdef DMEM_MISALIGN_EN
  assign mis_s = misaligned(be_i, addr_i[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  assign accept_s = req_i && ready_r;
  assign access_s = (state_r == BUSY) && (cnt_r == '0);

  // next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) next_state_s = BUSY; else next_state_s = IDLE;
      BUSY:    if (cnt_r == '0) next_state_s = RESP; else next_state_s = BUSY;
      RESP:    if (accept_s) next_state_s = BUSY; else next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // state, wait counter, captured request and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      we_r     <= 1'b0;
      mis_r    <= 1'b0;
      idx_r    <= '0;
      wd_r     <= 32'd0;
      be_r     <= 4'd0;
      ready_r  <= 1'b1;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      ready_r  <= (next_state_s != BUSY);
      rvalid_r <= (next_state_s == RESP);
      err_r    <= (next_state_s == RESP) && mis_r;
      if (accept_s) begin
        cnt_r <= LAT_LOAD;
        we_r  <= we_i;
        mis_r <= mis_s;
        idx_r <= addr_i[ADDR_W+1:2];
        wd_r  <= wd_i;
        be_r  <= be_i;
      end else if ((state_r == BUSY) && (cnt_r != '0)) begin
        cnt_r <= cnt_r - 1'b1;
      end
    end
  end

  // a misaligned write is dropped and a misaligned read returns zero
  ucsbece154b_bram_be #(.ADDR_W(ADDR_W)) u_bram (
    .clk   (clk),
    .rst_n (reset),
    .en    (access_s),
    .we    (we_r && !mis_r),
    .be    (be_r),
    .clr   (mis_r && !we_r),
    .idx   (idx_r),
    .wd    (wd_r),
    .rd    (rd_o)
  );

  assign ready_o  = ready_r;
  assign rvalid_o = rvalid_r;
  assign err_o    = err_r;

endmodule

// File: tb/tb_ucsbece154b_dmem_wait.sv
// Self-checking bench for ucsbece154b_dmem_wait: directed table, corner sequences,
// and random accesses against a word-array reference model.
module tb_ucsbece154b_dmem_wait;

  localparam int ADDR_W  = 6;
  localparam int LATENCY = 2;
  localparam int WORDS   = 2**ADDR_W;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wd = 32'd0;
  logic [3:0]  be = 4'd0;
  logic        ready, rvalid, err;
  logic [31:0] rd;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [WORDS];
  bit          known [WORDS];

  ucsbece154b_dmem_wait #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wd_i(wd), .be_i(be), .ready_o(ready), .rvalid_o(rvalid), .rd_o(rd), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: memory as an array of words, updated lane by lane.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, output logic [31:0] exp_rd,
                              output logic exp_err, output bit rd_known);
    int  i;
    bit  mis;
    i   = int'((a / 4) % WORDS);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_EN
    mis = ((b == 4'hF) && (a % 4 != 0)) || (((b == 4'h3) || (b == 4'hC)) && (a % 2 != 0));
`endif
    exp_err  = mis;
    rd_known = known[i];
    exp_rd   = model[i];
    if (!w) begin
      if (mis) begin
        exp_rd   = 32'd0;
        rd_known = 1'b1;
      end
    end else if (mis) begin
      rd_known = 1'b0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (b[n]) model[i][8*n +: 8] = d[8*n +: 8];
      if (b == 4'hF) known[i] = 1'b1;
    end
  endtask

  // One complete handshake; checks busy window and response latency.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] r, output logic e);
    int n;
    @(negedge clk);
    chk("ready_before_req", {31'd0, ready}, 32'd1);
    req = 1'b1; we = w; addr = a; wd = d; be = b;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (!rvalid && n < 40) begin
      chk("ready_busy", {31'd0, ready}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, LATENCY);
    chk("ready_resp", {31'd0, ready}, 32'd1);
    r = rd;
    e = err;
  endtask

  task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] exp_rd, r;
    logic        exp_err, e;
    bit          rk;
    model_access(w, a, d, b, exp_rd, exp_err, rk);
    access(w, a, d, b, r, e);
    chk("err", {31'd0, e}, {31'd0, exp_err});
    if (rk) chk("rd", r, exp_rd);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] r, exp_rd, old, addr_b2b;
    logic        e, exp_err;
    bit          rk;
    int          n;

    vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h10,  32'h0,        4'b1111, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h10,  32'h00AA00CC, 4'b0101, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 32'h10,  32'h0,        4'b0000, 1'b1, 32'hDEAABECC};
    vecs[4] = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'b0000, 1'b1, 32'hDEAABECC};
    vecs[5] = '{1'b0, 32'h110, 32'h0,        4'b1111, 1'b1, 32'hDEAABECC};
    vecs[6] = '{1'b1, 32'h4,   32'hCAFEF00D, 4'b1111, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h104, 32'h0,        4'b0110, 1'b1, 32'hCAFEF00D};
    vecs[8] = '{1'b0, 32'hFFFF_FF04, 32'h0,  4'b1111, 1'b1, 32'hCAFEF00D};

    // reset held for three cycles
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rd", rd, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
    end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("idle_ready", {31'd0, ready}, 32'd1);
      chk("idle_rvalid", {31'd0, rvalid}, 32'd0);
      chk("idle_rd", rd, 32'd0);
    end

    // directed table
    for (int v = 0; v < 9; v++) begin
      model_access(vecs[v].we, vecs[v].addr, vecs[v].wd, vecs[v].be, exp_rd, exp_err, rk);
      access(vecs[v].we, vecs[v].addr, vecs[v].wd, vecs[v].be, r, e);
      if (vecs[v].chk_rd) chk("table_rd", r, vecs[v].exp_rd);
      chk("table_err", {31'd0, e}, 32'd0);
    end

    // back-to-back aliased reads with req held high
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h104; be = 4'hF;
    @(posedge clk); #1;
    addr_b2b = 32'h4; addr = addr_b2b;
    n = 0;
    while (!rvalid && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_lat1", n, LATENCY);
    chk("b2b_rd1", rd, 32'hCAFEF00D);
    chk("b2b_ready_resp", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    chk("b2b_accepted", {31'd0, ready}, 32'd0);
    chk("b2b_rvalid_low", {31'd0, rvalid}, 32'd0);
    n = 1;
    while (!rvalid && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_gap", n, LATENCY + 1);
    chk("b2b_rd2", rd, 32'hCAFEF00D);

    // give every word a known value
    for (int i = 0; i < WORDS; i++) run(1'b1, 32'(i * 4), $urandom, 4'hF);

    // reset while busy drops the pending write
    old = model[8];
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'h12345678; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    chk("midrst_busy", {31'd0, ready}, 32'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_rd", rd, 32'd0);
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("midrst_no_rvalid", {31'd0, rvalid}, 32'd0);
    end
    access(1'b0, 32'h20, 32'h0, 4'hF, r, e);
    chk("midrst_old", r, old);

    // word write at a misaligned address
    run(1'b1, 32'h22, 32'hA5A5A5A5, 4'hF);
    access(1'b0, 32'h20, 32'h0, 4'hF, r, e);
`ifdef DMEM_MISALIGN_EN
    chk("mis_unchanged", r, old);
`else
    chk("mis_stored", r, 32'hA5A5A5A5);
`endif
    run(1'b0, 32'h23, 32'h0, 4'hC);

    // random traffic against the model
    for (int k = 0; k < 150; k++)
      run(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
